instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 79 +++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// Handshake: an entry moves to decode on a cycle where InstrValid and InstrReady are both high at the CLK rising edge.
interface instruction_fetch_unit_if;
  logic        FetchEn;
  logic [63:0] ImemAddr;
  logic [31:0] ImemData;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic [1:0]  Count;

  modport slave (
    input  FetchEn, ImemData, Redirect, RedirectPC, InstrReady,
    output ImemAddr, InstrValid, Instr, InstrPC, Count
  );

  modport master (
    output FetchEn, ImemData, Redirect, RedirectPC, InstrReady,
    input  ImemAddr, InstrValid, Instr, InstrPC, Count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register feeding a combinational instruction memory,
// with a 2-entry {PC, instruction} buffer toward decode and redirect flush.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic                         CLK,
  input logic                         Reset_L,
  instruction_fetch_unit_if.slave     bus
);

  logic [63:0] pc_q, pc_d;
  logic [63:0] ent_pc_q  [2];
  logic [63:0] ent_pc_d  [2];
  logic [31:0] ent_ins_q [2];
  logic [31:0] ent_ins_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic pop;
  logic push;

  assign pop  = (count_q != 2'd0) && bus.InstrReady;
  assign push = bus.FetchEn && !bus.Redirect && ((count_q != 2'd2) || pop);

  always_comb begin
    pc_d      = pc_q;
    ent_pc_d  = ent_pc_q;
    ent_ins_d = ent_ins_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (bus.Redirect) begin
      // A same-cycle pop still reaches decode; its entry is simply flushed here.
      pc_d     = {bus.RedirectPC[63:2], 2'b00};
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        ent_pc_d[wr_ptr_q]  = pc_q;
        ent_ins_d[wr_ptr_q] = bus.ImemData;
        wr_ptr_d            = ~wr_ptr_q;
        pc_d                = pc_q + 64'd4;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      pc_q         <= RESET_PC;
      ent_pc_q[0]  <= '0;
      ent_pc_q[1]  <= '0;
      ent_ins_q[0] <= '0;
      ent_ins_q[1] <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      pc_q      <= pc_d;
      ent_pc_q  <= ent_pc_d;
      ent_ins_q <= ent_ins_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign bus.ImemAddr   = pc_q;
  assign bus.Count      = count_q;
  assign bus.InstrValid = (count_q != 2'd0);
  assign bus.Instr      = (count_q != 2'd0) ? ent_ins_q[rd_ptr_q] : 32'h0;
  assign bus.InstrPC    = (count_q != 2'd0) ? ent_pc_q[rd_ptr_q]  : 64'h0;

endmodule
